spike_synapse: RTL and testbench

Synaptic current generator that turns incoming spike events into the 8-bit `current` drive consumed by the EIF neuron. Queued weighted spikes from upstream neurons or the spike router are accepted over a valid/ready handshake. Each event is added to (excitatory) or subtracted from (inhibitory) a saturating current register. The register decays exponentially toward zero between events.

---
 rtl/spike_synapse.sv | 148 ++++++++++++++
 tb/tb_spike_synapse.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_synapse.sv
// rtl/spike_synapse.sv - synaptic current generator: event FIFO, saturating accumulate, exponential decay
module spike_synapse #(
    parameter int DEPTH        = 4,
    parameter int DECAY_SHIFT  = 3,
    parameter int DECAY_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [7:0] ev_weight,
    input  logic       ev_inhibit,
    input  logic       refractory,
    output logic [7:0] current,
    output logic       sat,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Event storage: bit 8 is the inhibit flag, bits 7:0 the weight.
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cur_q, cur_d;
    logic          sat_q, sat_d;
    logic          busy_q;

    logic          push;
    logic          pop;
    logic          tick;
    logic [8:0]    head;
    logic [7:0]    dec_amt;
    logic signed [9:0] d_acc;
    logic signed [9:0] wt_s;

    // Handshake and queue control; pops only happen while ACTIVE and not refractory.
    always_comb begin
        push     = ev_valid && ready_q;
        pop      = (state_q == S_ACTIVE) && (count_q != '0) && !refractory;
        head     = mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Current update: decay first, then the popped event, then clamp to [0,255].
    always_comb begin
        tick    = (state_q == S_ACTIVE) && (cnt_q == CW'(DECAY_PERIOD - 1));
        dec_amt = cur_q >> DECAY_SHIFT;
        if (dec_amt == 8'd0) begin
            dec_amt = 8'd1;
        end
        wt_s  = signed'({2'b00, head[7:0]});
        d_acc = signed'({2'b00, cur_q});
        if (tick && (cur_q != 8'd0)) begin
            d_acc = d_acc - signed'({2'b00, dec_amt});
        end
        if (pop) begin
            if (head[8]) begin
                d_acc = d_acc - wt_s;
            end else begin
                d_acc = d_acc + wt_s;
            end
        end
        sat_d = 1'b0;
        cur_d = d_acc[7:0];
        if (d_acc < 10'sd0) begin
            cur_d = 8'd0;
            sat_d = 1'b1;
        end else if (d_acc > 10'sd255) begin
            cur_d = 8'd255;
            sat_d = 1'b1;
        end
    end

    // Next FSM state and decay counter; the counter only runs while staying ACTIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if ((cur_d == 8'd0) && (count_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = '0;
        if ((state_q == S_ACTIVE) && (state_d == S_ACTIVE)) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // FIFO storage write; pointers are reset, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {ev_inhibit, ev_weight};
        end
    end

    // FSM, queue pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            cnt_q    <= '0;
            cur_q    <= 8'd0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d != (AW+1)'(DEPTH));
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            sat_q    <= sat_d;
            busy_q   <= (state_d == S_ACTIVE);
        end
    end

    assign ev_ready = ready_q;
    assign current  = cur_q;
    assign sat      = sat_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spike_synapse.sv
// tb/tb_spike_synapse.sv - scoreboard bench for spike_synapse
module tb_spike_synapse;

    localparam int DEPTH        = 4;
    localparam int DECAY_SHIFT  = 3;
    localparam int DECAY_PERIOD = 4;

    logic       clk;
    logic       rst;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_weight;
    logic       ev_inhibit;
    logic       refractory;
    logic [7:0] current;
    logic       sat;
    logic       busy;

    typedef struct packed {
        logic [7:0] cur;
        logic       sat;
        logic       busy;
        logic       rdy;
    } exp_t;

    exp_t       sb_q[$];
    logic [8:0] m_fifo[$];
    int         m_cur   = 0;
    bit         m_sat   = 0;
    bit         m_busy  = 0;
    int         m_cnt   = 0;
    bit         m_ready = 1;

    int n_run  = 0;
    int n_fail = 0;

    spike_synapse #(
        .DEPTH       (DEPTH),
        .DECAY_SHIFT (DECAY_SHIFT),
        .DECAY_PERIOD(DECAY_PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_weight (ev_weight),
        .ev_inhibit(ev_inhibit),
        .refractory(refractory),
        .current   (current),
        .sat       (sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Drive one cycle of inputs, advance the reference model, queue its expectation, clock once.
    task automatic step(input logic v, input logic [7:0] w, input logic inh,
                        input logic refr, input logic r);
        int         d;
        int         dec;
        logic [8:0] hd;
        bit         push;
        bit         tick;
        bit         nb;
        exp_t       e;
        ev_valid   = v;
        ev_weight  = w;
        ev_inhibit = inh;
        refractory = refr;
        rst        = r;
        if (r) begin
            m_cur = 0; m_sat = 0; m_busy = 0; m_cnt = 0; m_ready = 1;
            m_fifo.delete();
        end else begin
            push = v && m_ready;
            d    = m_cur;
            tick = m_busy && (m_cnt == DECAY_PERIOD - 1);
            if (tick && m_cur > 0) begin
                dec = m_cur >> DECAY_SHIFT;
                if (dec < 1) dec = 1;
                d = d - dec;
            end
            if (m_busy && m_fifo.size() > 0 && !refr) begin
                hd = m_fifo.pop_front();
                if (hd[8]) d = d - int'(hd[7:0]);
                else       d = d + int'(hd[7:0]);
            end
            if (push) m_fifo.push_back({inh, w});
            m_sat = (d < 0) || (d > 255);
            m_cur = (d < 0) ? 0 : ((d > 255) ? 255 : d);
            nb = m_busy ? !(m_cur == 0 && m_fifo.size() == 0) : push;
            if (nb && m_busy) m_cnt = tick ? 0 : m_cnt + 1;
            else              m_cnt = 0;
            m_busy  = nb;
            m_ready = (m_fifo.size() != DEPTH);
        end
        e.cur  = 8'(m_cur);
        e.sat  = m_sat;
        e.busy = m_busy;
        e.rdy  = m_ready;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 8'd77, 1'b0, 1'b0, (c < 3));
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL reset c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
            if (c == 2) begin
                n_run++;
                if ({current, ev_ready, busy, sat} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL reset_state got cur=%0d rdy=%0b busy=%0b sat=%0b want 0/1/0/0",
                             current, ev_ready, busy, sat);
                end
                ev_valid = 1'b0;
            end
            if (c == 2) break;
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
        end
        n_run++;
        if (current !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept got cur=%0d busy=%0b want 0/0", current, busy);
        end
    endtask

    task automatic test_single_decay;
        exp_t e;
        int   c;
        step(1'b1, 8'd100, 1'b0, 1'b0, 1'b0);
        void'(sb_q.pop_front());
        c = 1;
        while (c < 400) begin
            step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL decay c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
            if (c == 1 || c == 4 || c == 8) begin
                n_run++;
                if (current !== ((c == 1) ? 8'd100 : (c == 4) ? 8'd88 : 8'd77)) begin
                    n_fail++;
                    $display("FAIL decay_point edge=%0d got %0d want %0d", c, current,
                             (c == 1) ? 100 : (c == 4) ? 88 : 77);
                end
            end
            if (!m_busy) break;
            c++;
        end
        n_run++;
        if (c >= 400 || current !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL decay_to_idle edge=%0d got cur=%0d busy=%0b want 0/0", c, current, busy);
        end
    endtask

    task automatic test_saturate;
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            step((c < 2), 8'd200, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL saturate c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
            if (c >= 1) begin
                n_run++;
                if ({current, sat} !== ((c == 1) ? {8'd200, 1'b0} : (c == 2) ? {8'd255, 1'b1} : {8'd255, 1'b0})) begin
                    n_fail++;
                    $display("FAIL saturate_point edge=%0d got cur=%0d sat=%0b", c, current, sat);
                end
            end
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        void'(sb_q.pop_front());
    endtask

    task automatic test_inhibit_clamp;
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            step((c < 2), (c == 0) ? 8'd30 : 8'd50, (c == 1), 1'b0, 1'b0);
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL inhibit c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
            if (c == 1 && current !== 8'd30) begin
                n_run++; n_fail++;
                $display("FAIL inhibit_pre got %0d want 30", current);
            end
            if (c == 2) begin
                n_run++;
                if ({current, sat, busy} !== {8'd0, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL inhibit_clamp got cur=%0d sat=%0b busy=%0b want 0/1/0", current, sat, busy);
                end
            end
        end
    endtask

    task automatic test_refractory;
        exp_t       e;
        logic [7:0] wt [5];
        int         ptr;
        bit         acc;
        wt = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        ptr = 0;
        for (int c = 0; c < 14; c++) begin
            acc = (ptr < 5) && m_ready;
            step((ptr < 5), wt[(ptr < 5) ? ptr : 4], 1'b0, (c < 6), 1'b0);
            if (acc) ptr++;
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL refractory c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
            if (c == 5) begin
                n_run++;
                if ({ev_ready, current} !== {1'b0, 8'd0}) begin
                    n_fail++;
                    $display("FAIL refractory_hold got rdy=%0b cur=%0d want 0/0", ev_ready, current);
                end
            end
            if (c == 6 || c == 7 || c == 10) begin
                n_run++;
                if (current !== ((c == 6) ? 8'd10 : (c == 7) ? 8'd30 : 8'd147)) begin
                    n_fail++;
                    $display("FAIL refractory_apply edge=%0d got %0d want %0d", c, current,
                             (c == 6) ? 10 : (c == 7) ? 30 : 147);
                end
            end
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        void'(sb_q.pop_front());
    endtask

    task automatic test_reset_mid_burst;
        exp_t e;
        for (int c = 0; c < 10; c++) begin
            step((c < 5), (c == 0) ? 8'd150 : 8'd60, 1'b0, (c == 2 || c == 3), (c == 4));
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL rst_mid c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
            if (c == 3) begin
                n_run++;
                if (current !== 8'd150) begin
                    n_fail++;
                    $display("FAIL rst_mid_pre got %0d want 150", current);
                end
                ev_valid = 1'b0;
            end
            if (c == 4) begin
                n_run++;
                if ({current, busy, ev_ready, sat} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rst_mid_clear got cur=%0d busy=%0b rdy=%0b sat=%0b want 0/0/1/0",
                             current, busy, ev_ready, sat);
                end
            end
            if (c == 3) begin
                step(1'b1, 8'd60, 1'b0, 1'b0, 1'b1);
                e = sb_q.pop_front();
                n_run++;
                if ({current, busy, ev_ready} !== {8'd0, 1'b0, 1'b1} || e.cur !== 8'd0) begin
                    n_fail++;
                    $display("FAIL rst_mid_edge got cur=%0d busy=%0b rdy=%0b want 0/0/1", current, busy, ev_ready);
                end
                break;
            end
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            n_run++;
            if ({current, sat, busy, ev_ready} !== e) begin
                n_fail++;
                $display("FAIL rst_mid_after c=%0d got cur=%0d sat=%0b busy=%0b rdy=%0b want cur=%0d sat=%0b busy=%0b rdy=%0b",
                         c, current, sat, busy, ev_ready, e.cur, e.sat, e.busy, e.rdy);
            end
        end
        n_run++;
        if (current !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_discard got cur=%0d busy=%0b want 0/0", current, busy);
        end
    endtask

    initial begin
        rst        = 1'b1;
        ev_valid   = 1'b0;
        ev_weight  = 8'd0;
        ev_inhibit = 1'b0;
        refractory = 1'b0;
        #1;
        test_reset();
        test_single_decay();
        test_saturate();
        test_inhibit_clamp();
        test_refractory();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
